// File: rtl/div_sched_if.sv
// Handshake bundle between the requesters, the divide scheduler and the divider.
// master = requester/divider side, slave = div_sched.
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef M_WIDTH
`define M_WIDTH 32
`endif

interface div_sched_if #(
    parameter int UOP_W = 3 + `LG_PRF_ENTRIES + `LG_ROB_ENTRIES + 2 * `M_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [UOP_W-1:0] req0_uop;
    logic             req1_valid;
    logic             req1_ready;
    logic [UOP_W-1:0] req1_uop;
    logic             div_start;
    logic [UOP_W-1:0] div_uop;
    logic             div_complete;
    logic             drop_result;

    modport master (
        output req0_valid, req0_uop, req1_valid, req1_uop, div_complete,
        input  req0_ready, req1_ready, div_start, div_uop, drop_result
    );

    modport slave (
        input  req0_valid, req0_uop, req1_valid, req1_uop, div_complete,
        output req0_ready, req1_ready, div_start, div_uop, drop_result
    );
endinterface

// File: rtl/div_sched.sv
// Divide-uop scheduler: two-requester arbiter, circular pending queue, issue FSM.
// Define DIV_SCHED_RR_EN for round-robin arbitration; fixed priority (req0) otherwise.
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef M_WIDTH
`define M_WIDTH 32
`endif

module div_sched #(
    parameter int LG_Q = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    div_sched_if.slave    bus,
    output logic [LG_Q:0] occupancy,
    output logic          busy
);
    localparam int Q     = 1 << LG_Q;
    localparam int UOP_W = 3 + `LG_PRF_ENTRIES + `LG_ROB_ENTRIES + 2 * `M_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [LG_Q:0]    head, tail;
    logic [UOP_W-1:0] q_mem [Q];
    logic             full, empty, can_acc;
    logic             accept0, accept1, push, issue;
    logic [UOP_W-1:0] push_uop;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty     = (head == tail);
    assign full      = (head[LG_Q] != tail[LG_Q]) && (head[LG_Q-1:0] == tail[LG_Q-1:0]);
    assign occupancy = tail - head;
    assign can_acc   = !full && !flush;

`ifdef DIV_SCHED_RR_EN
    logic rr_turn;  // 0: req0 wins a tie, 1: req1 wins a tie

    assign bus.req0_ready = can_acc && (!rr_turn || !bus.req1_valid);
    assign bus.req1_ready = can_acc && (rr_turn || !bus.req0_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_turn <= 1'b0;
        end else if (accept0) begin
            rr_turn <= 1'b1;
        end else if (accept1) begin
            rr_turn <= 1'b0;
        end
    end
`else
    assign bus.req0_ready = can_acc;
    assign bus.req1_ready = can_acc && !bus.req0_valid;
`endif

    assign accept0  = bus.req0_valid && bus.req0_ready;
    assign accept1  = bus.req1_valid && bus.req1_ready;
    assign push     = accept0 || accept1;
    assign push_uop = accept0 ? bus.req0_uop : bus.req1_uop;

    // Issue is driven by registered queue/FSM state; flush only suppresses it.
    assign issue           = (state == IDLE) && !empty && !flush;
    assign bus.div_start   = issue;
    assign bus.div_uop     = empty ? '0 : q_mem[head[LG_Q-1:0]];
    assign bus.drop_result = bus.div_complete &&
                             (((state == BUSY) && flush) || (state == DRAIN));
    assign busy            = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = BUSY;
            BUSY: begin
                if (flush)                  state_nxt = bus.div_complete ? IDLE : DRAIN;
                else if (bus.div_complete)  state_nxt = IDLE;
            end
            DRAIN:   if (bus.div_complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                head <= tail;
            end else begin
                if (push)  tail <= tail + (LG_Q + 1)'(1);
                if (issue) head <= head + (LG_Q + 1)'(1);
            end
        end
    end

    // Queue storage holds data only and is not reset.
    always_ff @(posedge clk) begin
        if (push) q_mem[tail[LG_Q-1:0]] <= push_uop;
    end
endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: reset, single issue, backlog, flush/drain, reset mid-op, arbitration.
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef M_WIDTH
`define M_WIDTH 32
`endif

module tb_div_sched;
    localparam int UOP_W = 3 + `LG_PRF_ENTRIES + `LG_ROB_ENTRIES + 2 * `M_WIDTH;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [2:0] occupancy;
    logic busy;
    int n_tests = 0;
    int n_fail = 0;

    div_sched_if bus ();

    div_sched #(.LG_Q(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [UOP_W-1:0] mk(input logic is_signed, input logic [`LG_ROB_ENTRIES-1:0] rob,
                                            input logic [`M_WIDTH-1:0] b, input logic [`M_WIDTH-1:0] a);
        logic [`LG_PRF_ENTRIES-1:0] prf;
        prf = `LG_PRF_ENTRIES'(rob) + `LG_PRF_ENTRIES'(1);
        return {1'b0, 1'b0, is_signed, prf, rob, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_uop = '0; bus.req1_uop = '0;
        bus.div_complete = 0; flush = 0;
    endtask

    task automatic push0(input logic [UOP_W-1:0] u);
        bus.req0_valid = 1; bus.req0_uop = u;
        tick();
        bus.req0_valid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (bus.div_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b exp 0", bus.div_start); end
        n_tests++; if (bus.div_uop !== '0) begin n_fail++; $display("FAIL reset_uop got %h exp 0", bus.div_uop); end
        // completion while idle is ignored
        bus.div_complete = 1; #1;
        n_tests++; if (bus.drop_result !== 1'b0) begin n_fail++; $display("FAIL idle_complete_drop got %b exp 0", bus.drop_result); end
        tick(); bus.div_complete = 0; #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_complete_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        logic [UOP_W-1:0] u;
        u = mk(1'b0, 5'd3, 32'd7, 32'd100);
        bus.req0_valid = 1; bus.req0_uop = u; #1;
        n_tests++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", bus.req0_ready); end
        n_tests++; if (bus.div_start !== 1'b0) begin n_fail++; $display("FAIL single_start0 got %b exp 0", bus.div_start); end
        tick(); bus.req0_valid = 0; #1;
        n_tests++; if (bus.div_start !== 1'b1) begin n_fail++; $display("FAIL single_start1 got %b exp 1", bus.div_start); end
        n_tests++; if (bus.div_uop !== u) begin n_fail++; $display("FAIL single_uop got %h exp %h", bus.div_uop, u); end
        n_tests++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL single_occ got %0d exp 1", occupancy); end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (busy !== 1'b1 || bus.div_start !== 1'b0) begin n_fail++; $display("FAIL single_busy got busy=%b start=%b exp 1/0", busy, bus.div_start); end
            tick();
        end
        bus.div_complete = 1; #1;
        n_tests++; if (bus.drop_result !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b exp 0", bus.drop_result); end
        tick(); bus.div_complete = 0; #1;
        n_tests++; if (busy !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL single_idle got busy=%b occ=%0d exp 0/0", busy, occupancy); end
    endtask

    task automatic test_backlog_flush();
        logic [UOP_W-1:0] u [5];
        for (int i = 0; i < 5; i++) u[i] = mk(1'b1, 5'(i + 8), 32'(i + 2), 32'(50 * i + 9));
        push0(u[0]);
        for (int i = 1; i < 5; i++) push0(u[i]);
        bus.req0_valid = 1; bus.req0_uop = u[0]; bus.req1_valid = 1; bus.req1_uop = u[1]; #1;
        n_tests++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL backlog_occ got %0d exp 4", occupancy); end
        n_tests++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL backlog_ready got %b%b exp 00", bus.req0_ready, bus.req1_ready); end
        n_tests++; if (bus.div_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL backlog_busy got start=%b busy=%b exp 0/1", bus.div_start, busy); end
        n_tests++; if (bus.div_uop !== u[1]) begin n_fail++; $display("FAIL backlog_head got %h exp %h", bus.div_uop, u[1]); end
        tick();
        clear_inputs(); bus.div_complete = 1;
        tick(); bus.div_complete = 0; #1;
        n_tests++; if (bus.div_start !== 1'b1 || bus.div_uop !== u[1]) begin n_fail++; $display("FAIL backlog_reissue got start=%b uop=%h exp 1/%h", bus.div_start, bus.div_uop, u[1]); end
        tick();
        n_tests++; if (occupancy !== 3'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL backlog_occ3 got occ=%0d busy=%b exp 3/1", occupancy, busy); end
        // flush in BUSY with three queued
        flush = 1; bus.req0_valid = 1; bus.req0_uop = u[4]; #1;
        n_tests++; if (bus.req0_ready !== 1'b0 || bus.div_start !== 1'b0) begin n_fail++; $display("FAIL flush_ready got ready=%b start=%b exp 0/0", bus.req0_ready, bus.div_start); end
        tick(); clear_inputs(); #1;
        n_tests++; if (occupancy !== 3'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL flush_drain got occ=%0d busy=%b exp 0/1", occupancy, busy); end
        for (int i = 0; i < 4; i++) begin
            flush = (i == 1); #1;
            n_tests++; if (bus.div_start !== 1'b0 || bus.drop_result !== 1'b0) begin n_fail++; $display("FAIL drain_wait got start=%b drop=%b exp 0/0", bus.div_start, bus.drop_result); end
            tick(); flush = 0;
        end
        bus.div_complete = 1; #1;
        n_tests++; if (bus.drop_result !== 1'b1) begin n_fail++; $display("FAIL drain_drop got %b exp 1", bus.drop_result); end
        tick(); bus.div_complete = 0; #1;
        n_tests++; if (busy !== 1'b0 || bus.div_start !== 1'b0 || bus.drop_result !== 1'b0) begin n_fail++; $display("FAIL drain_idle got busy=%b start=%b drop=%b exp 000", busy, bus.div_start, bus.drop_result); end
    endtask

    task automatic test_flush_complete();
        push0(mk(1'b1, 5'd20, 32'hFFFF_FFF9, 32'd64));
        tick();
        bus.req0_valid = 1; bus.req0_uop = mk(1'b0, 5'd21, 32'd3, 32'd9);
        flush = 1; bus.div_complete = 1; #1;
        n_tests++; if (bus.drop_result !== 1'b1) begin n_fail++; $display("FAIL fc_drop got %b exp 1", bus.drop_result); end
        n_tests++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL fc_ready got %b exp 0", bus.req0_ready); end
        tick(); clear_inputs(); #1;
        n_tests++; if (busy !== 1'b0 || occupancy !== 3'd0 || bus.div_start !== 1'b0) begin n_fail++; $display("FAIL fc_idle got busy=%b occ=%0d start=%b exp 0/0/0", busy, occupancy, bus.div_start); end
    endtask

    task automatic test_reset_mid();
        logic [UOP_W-1:0] u;
        push0(mk(1'b0, 5'd1, 32'd5, 32'd11));
        push0(mk(1'b0, 5'd2, 32'd6, 32'd12));
        push0(mk(1'b0, 5'd3, 32'd7, 32'd13));
        #1;
        n_tests++; if (busy !== 1'b1 || occupancy !== 3'd2) begin n_fail++; $display("FAIL rmid_pre got busy=%b occ=%0d exp 1/2", busy, occupancy); end
        reset = 1;
        tick(); reset = 0; #1;
        n_tests++; if (busy !== 1'b0 || occupancy !== 3'd0 || bus.div_start !== 1'b0 || bus.drop_result !== 1'b0 || bus.div_uop !== '0)
            begin n_fail++; $display("FAIL rmid_reset got busy=%b occ=%0d start=%b drop=%b exp 0/0/0/0", busy, occupancy, bus.div_start, bus.drop_result); end
        u = mk(1'b1, 5'd30, 32'd4, 32'd99);
        push0(u); #1;
        n_tests++; if (bus.div_start !== 1'b1 || bus.div_uop !== u) begin n_fail++; $display("FAIL rmid_issue got start=%b uop=%h exp 1/%h", bus.div_start, bus.div_uop, u); end
        tick(); bus.div_complete = 1; tick(); bus.div_complete = 0;
    endtask

    task automatic test_arbitration();
        logic [UOP_W-1:0] mq [$];
        logic exp_turn;
        logic g0, g1;
        int grants;
        reset = 1; clear_inputs(); tick(); reset = 0;
        exp_turn = 0; grants = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.req0_valid = 1; bus.req0_uop = mk(1'b0, 5'd4, 32'd3, 32'(1000 + cyc));
            bus.req1_valid = 1; bus.req1_uop = mk(1'b1, 5'd5, 32'd3, 32'(2000 + cyc));
            bus.div_complete = (cyc % 3 == 2);
            #1;
            g0 = bus.req0_ready; g1 = bus.req1_ready;
            n_tests++; if (occupancy !== 3'(mq.size())) begin n_fail++; $display("FAIL arb_occ c%0d got %0d exp %0d", cyc, occupancy, mq.size()); end
`ifdef DIV_SCHED_RR_EN
            n_tests++; if ((g0 | g1) !== (mq.size() < 4) || (g0 && exp_turn) || (g1 && !exp_turn))
                begin n_fail++; $display("FAIL arb_rr c%0d got g0=%b g1=%b exp turn=%0d", cyc, g0, g1, exp_turn); end
`else
            n_tests++; if (g1 !== 1'b0 || g0 !== (mq.size() < 4)) begin n_fail++; $display("FAIL arb_fixed c%0d got g0=%b g1=%b exp %b/0", cyc, g0, g1, mq.size() < 4); end
`endif
            if (bus.div_start) begin
                n_tests++; if (mq.size() == 0 || bus.div_uop !== mq[0]) begin n_fail++; $display("FAIL arb_order c%0d got %h", cyc, bus.div_uop); end
                if (mq.size() != 0) void'(mq.pop_front());
            end
            if (g0) begin mq.push_back(bus.req0_uop); exp_turn = 1; grants++; end
            else if (g1) begin mq.push_back(bus.req1_uop); exp_turn = 0; grants++; end
            tick();
        end
        n_tests++; if (grants < 5) begin n_fail++; $display("FAIL arb_grants got %0d exp >=5", grants); end
        clear_inputs();
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_single();
        test_backlog_flush();
        test_flush_complete();
        test_reset_mid();
        test_arbitration();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
